// File: rtl/ni_flit_injector.sv
// Credit-gated packet-to-flit injector feeding a NoC router local port.
// state | meaning
// IDLE  | waiting for a packet request
// HDR   | header flit pending a credit on the packet's VC
// BODY  | streaming body flits while credits and payload are available
module ni_flit_injector #(
    parameter int V    = 2,
    parameter int B    = 4,
    parameter int Fpay = 32,
    parameter int EAw  = 2,
    parameter int LENw = 8,
    parameter int Fw   = Fpay + V + 2,
    parameter int VCw  = (V > 1) ? $clog2(V) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [EAw-1:0]  current_e_addr,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [EAw-1:0]  req_dest,
    input  logic [VCw-1:0]  req_vc,
    input  logic [LENw-1:0] req_len,
    input  logic            data_valid,
    output logic            data_ready,
    input  logic [Fpay-1:0] data,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_wr,
    input  logic [V-1:0]    credit_in,
    output logic            busy,
    output logic            credit_err
);

    localparam int CNTw = $clog2(B + 1);
    localparam logic [CNTw-1:0] B_CNT = CNTw'(B);

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t                     state;
    logic [V-1:0][CNTw-1:0]     cnt;
    logic [EAw-1:0]             dest_q;
    logic [VCw-1:0]             vc_q;
    logic [LENw-1:0]            len_q;
    logic [LENw-1:0]            remaining;

    logic                       avail;
    logic                       send;
    logic [V-1:0]               vc_oh;
    logic [Fpay-1:0]            hdr_payload;

    always_comb begin
        avail = (cnt[vc_q] != '0);
        send  = 1'b0;
        if (state == HDR)
            send = avail;
        else if (state == BODY)
            send = avail && data_valid;
        vc_oh        = '0;
        vc_oh[vc_q]  = 1'b1;
        hdr_payload  = '0;
        hdr_payload[EAw-1:0]             = dest_q;
        hdr_payload[2*EAw-1:EAw]         = current_e_addr;
        hdr_payload[2*EAw+LENw-1:2*EAw]  = len_q;
    end

    // Ready signals are gated by reset so nothing is accepted while the block is held.
    assign req_ready  = reset && (state == IDLE);
    assign data_ready = reset && (state == BODY) && avail;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= {V{B_CNT}};
            dest_q      <= '0;
            vc_q        <= '0;
            len_q       <= '0;
            remaining   <= '0;
            flit_out    <= '0;
            flit_out_wr <= 1'b0;
            busy        <= 1'b0;
            credit_err  <= 1'b0;
        end else begin
            flit_out_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        dest_q <= req_dest;
                        vc_q   <= req_vc;
                        len_q  <= req_len;
                        state  <= HDR;
                        busy   <= 1'b1;
                    end
                end
                HDR: begin
                    if (send) begin
                        flit_out    <= {1'b1, (len_q == '0), vc_oh, hdr_payload};
                        flit_out_wr <= 1'b1;
                        remaining   <= len_q;
                        if (len_q == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (send) begin
                        flit_out    <= {1'b0, (remaining == LENw'(1)), vc_oh, data};
                        flit_out_wr <= 1'b1;
                        remaining   <= remaining - LENw'(1);
                        if (remaining == LENw'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A send and a credit return on the same VC cancel out.
            for (int v = 0; v < V; v++) begin
                if (credit_in[v] && !(send && (vc_q == VCw'(v)))) begin
                    if (cnt[v] == B_CNT)
                        credit_err <= 1'b1;
                    else
                        cnt[v] <= cnt[v] + CNTw'(1);
                end else if (!credit_in[v] && send && (vc_q == VCw'(v))) begin
                    cnt[v] <= cnt[v] - CNTw'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ni_flit_injector.sv
// Directed bench for ni_flit_injector: table of per-cycle vectors plus hand-written corner sequences.
module tb_ni_flit_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  current_e_addr;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_dest;
    logic [0:0]  req_vc;
    logic [7:0]  req_len;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data;
    logic [35:0] flit_out;
    logic        flit_out_wr;
    logic [1:0]  credit_in;
    logic        busy;
    logic        credit_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ni_flit_injector dut (
        .clk(clk), .reset(reset), .current_e_addr(current_e_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest),
        .req_vc(req_vc), .req_len(req_len), .data_valid(data_valid),
        .data_ready(data_ready), .data(data), .flit_out(flit_out),
        .flit_out_wr(flit_out_wr), .credit_in(credit_in), .busy(busy),
        .credit_err(credit_err)
    );

    typedef struct {
        logic        rv;
        logic [1:0]  dest;
        logic        vc;
        logic [7:0]  len;
        logic [1:0]  cur;
        logic        dv;
        logic [31:0] dat;
        logic [1:0]  cr;
        logic        e_rr;
        logic        e_dr;
        logic        e_wr;
        logic        e_busy;
        logic [35:0] e_flit;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic rv, logic [1:0] dest, logic vc, logic [7:0] len,
                                logic [1:0] cur, logic dv, logic [31:0] dat, logic [1:0] cr,
                                logic e_rr, logic e_dr, logic e_wr, logic e_busy,
                                logic [35:0] e_flit);
        vec_t t;
        t.rv = rv; t.dest = dest; t.vc = vc; t.len = len; t.cur = cur;
        t.dv = dv; t.dat = dat; t.cr = cr;
        t.e_rr = e_rr; t.e_dr = e_dr; t.e_wr = e_wr; t.e_busy = e_busy; t.e_flit = e_flit;
        return t;
    endfunction

    task automatic idle_inputs();
        req_valid = 0; req_dest = 0; req_vc = 0; req_len = 0;
        data_valid = 0; data = 0; credit_in = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nflit;
        logic [31:0] word;
        logic hs;
        logic [35:0] last_flit;

        reset = 0;
        current_e_addr = 0;
        idle_inputs();

        // dest=3 vc=1 len=2 cur=0: header payload 0x23, VC 2'b10
        vecs.push_back(mk(1, 3, 1, 2, 0, 0, 0,            0, 1, 0, 0, 1, 36'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 1, 36'hA_0000_0023));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 0, 0, 1, 1, 1, 36'h2_A5A5A5A5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h5A5A5A5A, 0, 0, 1, 1, 0, 36'h6_5A5A5A5A));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 1, 0, 0, 0, 36'h0));
        // len=0 vc=0 dest=1 cur=2: single flit hdr+tail, payload 0x9
        vecs.push_back(mk(1, 1, 0, 0, 2, 0, 0,            0, 1, 0, 0, 1, 36'h0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 0, 0,            0, 0, 0, 1, 0, 36'hD_0000_0009));
        vecs.push_back(mk(0, 0, 0, 0, 2, 0, 0,            0, 1, 0, 0, 0, 36'h0));
        // return credits: cnt[0] 3->4, cnt[1] 1->4
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            3, 1, 0, 0, 0, 36'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            2, 1, 0, 0, 0, 36'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            2, 1, 0, 0, 0, 36'h0));

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_data_ready", data_ready, 0);
        check("rst_flit_wr", flit_out_wr, 0);
        check("rst_flit", flit_out, 0);
        reset = 1;
        #1;
        check("idle_req_ready", req_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_cnt0", dut.cnt[0], 4);
        check("idle_cnt1", dut.cnt[1], 4);
        check("idle_credit_err", credit_err, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            req_valid = vecs[i].rv; req_dest = vecs[i].dest; req_vc = vecs[i].vc;
            req_len = vecs[i].len; current_e_addr = vecs[i].cur;
            data_valid = vecs[i].dv; data = vecs[i].dat; credit_in = vecs[i].cr;
            #1;
            check($sformatf("v%0d_req_ready", i), req_ready, vecs[i].e_rr);
            check($sformatf("v%0d_data_ready", i), data_ready, vecs[i].e_dr);
            tick();
            check($sformatf("v%0d_flit_wr", i), flit_out_wr, vecs[i].e_wr);
            check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            if (vecs[i].e_wr)
                check($sformatf("v%0d_flit", i), flit_out, vecs[i].e_flit);
            if (i == 4)
                check("after_pkt_cnt1", dut.cnt[1], 1);
        end
        idle_inputs();
        current_e_addr = 0;
        check("restored_cnt0", dut.cnt[0], 4);
        check("restored_cnt1", dut.cnt[1], 4);

        // credit starvation: vc0 len6, only 4 flits may go
        req_valid = 1; req_dest = 2; req_vc = 0; req_len = 6;
        tick();
        idle_inputs();
        nflit = 0;
        word = 32'd100;
        for (int c = 0; c < 12; c++) begin
            data_valid = 1; data = word;
            #1;
            hs = data_ready;
            tick();
            if (flit_out_wr) nflit++;
            if (hs) word++;
        end
        check("stall_flits", nflit, 4);
        #1;
        check("stall_data_ready", data_ready, 0);
        check("stall_busy", busy, 1);
        check("stall_cnt0", dut.cnt[0], 0);

        nflit = 0;
        last_flit = '0;
        for (int c = 0; c < 6; c++) begin
            credit_in = (c == 0) ? 2'b01 : 2'b00;
            data_valid = 1; data = word;
            #1;
            hs = data_ready;
            tick();
            if (flit_out_wr) begin
                nflit++;
                last_flit = flit_out;
            end
            if (hs) word++;
        end
        check("release_flits", nflit, 1);
        check("release_flit", last_flit, 36'h1_0000_0067);

        // send and credit return on vc0 in the same cycle
        data_valid = 0; credit_in = 2'b01;
        tick();
        check("pre_same_cnt0", dut.cnt[0], 1);
        data_valid = 1; data = 32'hCAFE0001; credit_in = 2'b01;
        tick();
        check("same_cycle_wr", flit_out_wr, 1);
        check("same_cycle_cnt0", dut.cnt[0], 1);
        credit_in = 0; data = 32'hCAFE0002;
        tick();
        check("tail_flit", flit_out, 36'h5_CAFE0002);
        check("tail_busy", busy, 0);
        data_valid = 0;
        repeat (4) begin
            credit_in = 2'b01;
            tick();
        end
        credit_in = 0;
        check("refill_cnt0", dut.cnt[0], 4);

        // spurious credit on full vc1 -> sticky error
        check("pre_err", credit_err, 0);
        credit_in = 2'b10;
        tick();
        credit_in = 0;
        check("err_set", credit_err, 1);
        check("err_cnt1_sat", dut.cnt[1], 4);
        repeat (3) tick();
        check("err_sticky", credit_err, 1);

        // reset in the middle of BODY
        req_valid = 1; req_dest = 1; req_vc = 1; req_len = 3;
        tick();
        idle_inputs();
        tick();
        data_valid = 1; data = 32'h11111111;
        tick();
        check("mid_busy", busy, 1);
        reset = 0;
        #1;
        check("rstlow_req_ready", req_ready, 0);
        check("rstlow_data_ready", data_ready, 0);
        tick();
        check("midrst_wr", flit_out_wr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cnt0", dut.cnt[0], 4);
        check("midrst_cnt1", dut.cnt[1], 4);
        check("midrst_err", credit_err, 0);
        reset = 1;
        idle_inputs();
        #1;
        check("midrst_req_ready", req_ready, 1);
        current_e_addr = 1;
        req_valid = 1; req_dest = 2; req_vc = 0; req_len = 1;
        tick();
        idle_inputs();
        tick();
        check("newhdr_wr", flit_out_wr, 1);
        check("newhdr_flit", flit_out, 36'h9_0000_0016);
        data_valid = 1; data = 32'h0BADF00D;
        tick();
        check("newbody_flit", flit_out, 36'h5_0BADF00D);
        check("newbody_busy", busy, 0);
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ni_flit_injector.md
# ni_flit_injector

Credit-based packet-to-flit injector in a tile's network interface, directly upstream of a NoC router local port. It takes one packet request (destination, VC, length) plus a stream of payload words from the tile side. It emits a header flit and then body flits on the router's `flit_in`/`flit_in_wr` port. Per-VC credits returned by the router gate every flit, so the router's input buffers never overflow.

## Interface
Parameters:
- `V`, 2: number of virtual channels.
- `B`, 4: router input buffer depth per VC in flits; this is the initial credit count.
- `Fpay`, 32: flit payload width.
- `EAw`, 2: endpoint address width.
- `LENw`, 8: width of the body-length field.
- `Fw`, Fpay+V+2 (36 at defaults): flit width. Bit Fw-1 = hdr, bit Fw-2 = tail, bits [Fw-3:Fpay] = one-hot VC, bits [Fpay-1:0] = payload.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-low.
- `current_e_addr` in EAw: this endpoint's address; static.
- `req_valid` in 1: a packet request is presented.
- `req_ready` out 1: the request is accepted on `req_valid && req_ready`.
- `req_dest` in EAw: destination endpoint address.
- `req_vc` in log2(V): VC index for the packet.
- `req_len` in LENw: number of body flits, 0..2^LENw-1.
- `data_valid` in 1: a payload word is presented.
- `data_ready` out 1: the word is consumed on `data_valid && data_ready`.
- `data` in Fpay: payload word.
- `flit_out` out Fw: flit to the router.
- `flit_out_wr` out 1: `flit_out` is valid this cycle.
- `credit_in` in V: one-cycle pulse per VC; each pulse returns one buffer slot.
- `busy` out 1: a packet is in progress.
- `credit_err` out 1: sticky flag, set when a credit arrives for a VC whose counter is already at B.

## Operation
- FSM states:
  - IDLE: `req_ready=1`. A handshake latches `dest`, `vc`, `len` and moves to HDR.
  - HDR: the header flit is sent when `cnt[vc]!=0`. If `len==0` the next state is IDLE; otherwise BODY, with `remaining=len`.
  - BODY: `data_ready = (cnt[vc]!=0)`. Each handshake sends one body flit and decrements `remaining`. When the handshake takes `remaining` to 0, the next state is IDLE.
- Header flit:
  - hdr=1.
  - tail=1 only if len==0.
  - VC field = one-hot(vc).
  - payload[EAw-1:0]=dest.
  - payload[2EAw-1:EAw]=current_e_addr.
  - payload[2EAw+LENw-1:2EAw]=len.
  - All other payload bits are 0.
- Body flit:
  - hdr=0.
  - tail=1 on the last body flit.
  - VC field = one-hot(vc).
  - payload = `data`.
- Credit counters, one per VC, each log2(B+1) bits wide, reset to B:
  - Flit sent on v: counter decrements.
  - `credit_in[v]` pulse: counter increments.
  - Both in the same cycle: counter is unchanged.
  - Increment while the counter is at B: counter saturates at B and `credit_err` is set.
  - A counter never goes below 0, because sending requires a nonzero counter.
- `busy` is 1 in HDR and BODY.
- Reset asserted mid-packet: the partial packet is abandoned and the FSM returns to IDLE. The router is reset in the same cycle.

## Timing
- Reset values:
  - `flit_out_wr=0`, `flit_out=0`.
  - `busy=0`, `credit_err=0`, all counters = B, state = IDLE.
  - `req_ready=0` and `data_ready=0` while `reset` is low.
- `flit_out` and `flit_out_wr` are registered. The flit for a send decision made in cycle n appears in cycle n+1 with `flit_out_wr=1` for exactly one cycle.
- Request accepted in cycle n → state is HDR in n+1. With a credit available, the header is decided in n+1 and appears in n+2.
- Throughput: one flit per cycle while credits and data are available. The decrement caused by a send is visible in the next cycle's availability check.
- Credit return: a `credit_in[v]` pulse in cycle n makes `cnt[v]` nonzero in n+1, allowing a send decision in n+1.
- `req_ready` and `data_ready` are combinational from the state and counters only, never from `req_valid` or `data_valid`.
- `data_valid` low in BODY: no flit is sent that cycle and the state holds.

## Test plan
- Reset then idle: `flit_out_wr=0`, `req_ready=1`, `busy=0`, and `cnt=4` on both VCs.
- Request dest=3, vc=1, len=2, current_e_addr=0, data 0xA5A5A5A5 then 0x5A5A5A5A, no backpressure:
  - Three consecutive flits starting two cycles after acceptance.
  - Header payload = 0x23; hdr=1, tail=0, VC=2'b10.
  - Last body flit has tail=1.
  - `cnt[1]=1` afterwards.
- len=0, vc=0: a single flit with hdr=1, tail=1, payload[EAw+:EAw]=current_e_addr; the FSM is back in IDLE one cycle after the send decision.
- No credits returned, vc=0, len=6:
  - Exactly 4 flits are sent, then `data_ready=0` and the FSM stalls.
  - One `credit_in[0]` pulse releases exactly one more flit.
- Send on vc=0 and `credit_in[0]` in the same cycle: the counter is unchanged. A `credit_in[1]` pulse while `cnt[1]=4` sets `credit_err=1` and it stays set until reset.
- Reset driven low in the middle of BODY:
  - Next cycle: IDLE, `flit_out_wr=0`, counters = 4.
  - A new request afterwards produces a correct header.
